// File: rtl/register_status_file_if.sv
// Decoder-issue and ROB-commit signal bundle for the register status file.
// The master side is the decoder/ROB; the slave side is the register file itself.
interface register_status_file_if #(
  parameter int unsigned TAG_WIDTH  = 4,
  parameter int unsigned REG_COUNT  = 32,
  parameter int unsigned WORD_WIDTH = 32
);
  localparam int unsigned IDX_WIDTH = $clog2(REG_COUNT);

  logic                  rollback_in;
  logic                  dec_issue_in;
  logic [IDX_WIDTH-1:0]  dec_rs1_in;
  logic [IDX_WIDTH-1:0]  dec_rs2_in;
  logic [IDX_WIDTH-1:0]  dec_rd_in;
  logic [TAG_WIDTH-1:0]  dec_rd_tag_in;
  logic [TAG_WIDTH-1:0]  dec_Qj_out;
  logic [TAG_WIDTH-1:0]  dec_Qk_out;
  logic [WORD_WIDTH-1:0] dec_Vj_out;
  logic [WORD_WIDTH-1:0] dec_Vk_out;
  logic                  commit_rf_signal_in;
  logic [TAG_WIDTH-1:0]  commit_tag_in;
  logic [WORD_WIDTH-1:0] commit_data_in;
  logic [IDX_WIDTH-1:0]  commit_target_in;

  modport master (
    output rollback_in, dec_issue_in, dec_rs1_in, dec_rs2_in, dec_rd_in, dec_rd_tag_in,
    output commit_rf_signal_in, commit_tag_in, commit_data_in, commit_target_in,
    input  dec_Qj_out, dec_Qk_out, dec_Vj_out, dec_Vk_out
  );

  modport slave (
    input  rollback_in, dec_issue_in, dec_rs1_in, dec_rs2_in, dec_rd_in, dec_rd_tag_in,
    input  commit_rf_signal_in, commit_tag_in, commit_data_in, commit_target_in,
    output dec_Qj_out, dec_Qk_out, dec_Vj_out, dec_Vk_out
  );
endinterface

// File: rtl/register_status_file.sv
// Architectural register file with per-register rename tags (Tomasulo result status).
// Tag 0 means the value held here is current; x0 is hard-wired to zero/ready.
module register_status_file #(
  parameter int unsigned TAG_WIDTH  = 4,
  parameter int unsigned REG_COUNT  = 32,
  parameter int unsigned WORD_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  register_status_file_if.slave bus
);
  localparam int unsigned IDX_WIDTH = $clog2(REG_COUNT);

  logic [WORD_WIDTH-1:0] value_q [REG_COUNT];
  logic [WORD_WIDTH-1:0] value_d [REG_COUNT];
  logic [TAG_WIDTH-1:0]  tag_q   [REG_COUNT];
  logic [TAG_WIDTH-1:0]  tag_d   [REG_COUNT];

  logic commit_we;
  logic issue_we;

  assign commit_we = bus.commit_rf_signal_in && (bus.commit_target_in != '0);
  assign issue_we  = bus.dec_issue_in && !bus.rollback_in && (bus.dec_rd_in != '0);

  // Read ports see pre-update state, with the committing result forwarded when it
  // resolves exactly the tag the register is waiting on.
  always_comb begin
    bus.dec_Qj_out = '0;
    bus.dec_Vj_out = '0;
    if (bus.dec_rs1_in != '0) begin
      if (bus.commit_rf_signal_in && (bus.commit_target_in == bus.dec_rs1_in) &&
          (tag_q[bus.dec_rs1_in] == bus.commit_tag_in)) begin
        bus.dec_Vj_out = bus.commit_data_in;
      end else begin
        bus.dec_Qj_out = tag_q[bus.dec_rs1_in];
        bus.dec_Vj_out = value_q[bus.dec_rs1_in];
      end
    end
  end

  always_comb begin
    bus.dec_Qk_out = '0;
    bus.dec_Vk_out = '0;
    if (bus.dec_rs2_in != '0) begin
      if (bus.commit_rf_signal_in && (bus.commit_target_in == bus.dec_rs2_in) &&
          (tag_q[bus.dec_rs2_in] == bus.commit_tag_in)) begin
        bus.dec_Vk_out = bus.commit_data_in;
      end else begin
        bus.dec_Qk_out = tag_q[bus.dec_rs2_in];
        bus.dec_Vk_out = value_q[bus.dec_rs2_in];
      end
    end
  end

  // Order matters: rollback clears after the commit, and a new issue overrides the
  // commit's tag clear on the same register.
  always_comb begin
    value_d = value_q;
    tag_d   = tag_q;
    if (commit_we) begin
      value_d[bus.commit_target_in] = bus.commit_data_in;
      if (tag_q[bus.commit_target_in] == bus.commit_tag_in) begin
        tag_d[bus.commit_target_in] = '0;
      end
    end
    if (bus.rollback_in) begin
      for (int i = 0; i < int'(REG_COUNT); i++) begin
        tag_d[i] = '0;
      end
    end else if (issue_we) begin
      tag_d[bus.dec_rd_in] = bus.dec_rd_tag_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(REG_COUNT); i++) begin
        value_q[i] <= '0;
        tag_q[i]   <= '0;
      end
    end else begin
      value_q <= value_d;
      tag_q   <= tag_d;
    end
  end

  logic [IDX_WIDTH-1:0] unused_idx;
  assign unused_idx = '0;

endmodule

// File: tb/tb_register_status_file.sv
// Directed bench for register_status_file: issue, commit, bypass, rollback, x0 and reset.
module tb_register_status_file;
  localparam int unsigned TAG_WIDTH  = 4;
  localparam int unsigned REG_COUNT  = 32;
  localparam int unsigned WORD_WIDTH = 32;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  register_status_file_if #(
    .TAG_WIDTH (TAG_WIDTH),
    .REG_COUNT (REG_COUNT),
    .WORD_WIDTH(WORD_WIDTH)
  ) bus ();

  register_status_file #(
    .TAG_WIDTH (TAG_WIDTH),
    .REG_COUNT (REG_COUNT),
    .WORD_WIDTH(WORD_WIDTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.rollback_in         = 1'b0;
    bus.dec_issue_in        = 1'b0;
    bus.dec_rd_in           = '0;
    bus.dec_rd_tag_in       = '0;
    bus.commit_rf_signal_in = 1'b0;
    bus.commit_tag_in       = '0;
    bus.commit_data_in      = '0;
    bus.commit_target_in    = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [3:0] tag);
    bus.dec_issue_in  = 1'b1;
    bus.dec_rd_in     = rd;
    bus.dec_rd_tag_in = tag;
  endtask

  task automatic commit(input logic [4:0] tgt, input logic [3:0] tag, input logic [31:0] data);
    bus.commit_rf_signal_in = 1'b1;
    bus.commit_target_in    = tgt;
    bus.commit_tag_in       = tag;
    bus.commit_data_in      = data;
  endtask

  task automatic read(input logic [4:0] rs1, input logic [4:0] rs2);
    bus.dec_rs1_in = rs1;
    bus.dec_rs2_in = rs2;
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clear_inputs();
    bus.dec_rs1_in = '0;
    bus.dec_rs2_in = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // 1: reset state
    read(5'd5, 5'd0);
    check_eq("rst_qj", 32'(bus.dec_Qj_out), 32'd0);
    check_eq("rst_vj", bus.dec_Vj_out, 32'd0);
    check_eq("rst_qk", 32'(bus.dec_Qk_out), 32'd0);
    check_eq("rst_vk", bus.dec_Vk_out, 32'd0);

    // 2: rename, bypass on both ports, then storage
    issue(5'd3, 4'd2);
    step();
    clear_inputs();
    read(5'd3, 5'd3);
    check_eq("t2_qj_pending", 32'(bus.dec_Qj_out), 32'd2);
    check_eq("t2_qk_pending", 32'(bus.dec_Qk_out), 32'd2);
    commit(5'd3, 4'd2, 32'h1234);
    #1;
    check_eq("t2_byp_qj", 32'(bus.dec_Qj_out), 32'd0);
    check_eq("t2_byp_vj", bus.dec_Vj_out, 32'h1234);
    check_eq("t2_byp_qk", 32'(bus.dec_Qk_out), 32'd0);
    check_eq("t2_byp_vk", bus.dec_Vk_out, 32'h1234);
    step();
    clear_inputs();
    #1;
    check_eq("t2_st_qj", 32'(bus.dec_Qj_out), 32'd0);
    check_eq("t2_st_vj", bus.dec_Vj_out, 32'h1234);

    // issuing instruction reads its own destination's old status
    issue(5'd3, 4'd7);
    read(5'd3, 5'd0);
    check_eq("self_read_qj", 32'(bus.dec_Qj_out), 32'd0);
    step();
    clear_inputs();
    #1;
    check_eq("self_read_after", 32'(bus.dec_Qj_out), 32'd7);
    commit(5'd3, 4'd7, 32'h1234);
    step();
    clear_inputs();

    // 3: younger rename survives older commit
    issue(5'd4, 4'd1);
    step();
    issue(5'd4, 4'd5);
    step();
    clear_inputs();
    commit(5'd4, 4'd1, 32'd7);
    read(5'd4, 5'd0);
    check_eq("t3_nobyp_qj", 32'(bus.dec_Qj_out), 32'd5);
    step();
    clear_inputs();
    #1;
    check_eq("t3_qj", 32'(bus.dec_Qj_out), 32'd5);
    check_eq("t3_val7", bus.dec_Vj_out, 32'd7);
    commit(5'd4, 4'd5, 32'd9);
    step();
    clear_inputs();
    #1;
    check_eq("t3_final_qj", 32'(bus.dec_Qj_out), 32'd0);
    check_eq("t3_final_vj", bus.dec_Vj_out, 32'd9);

    // 4: same-cycle commit and issue on one register
    issue(5'd6, 4'd3);
    step();
    clear_inputs();
    commit(5'd6, 4'd3, 32'hAA);
    issue(5'd6, 4'd4);
    step();
    clear_inputs();
    read(5'd6, 5'd0);
    check_eq("t4_qj", 32'(bus.dec_Qj_out), 32'd4);
    check_eq("t4_vj", bus.dec_Vj_out, 32'hAA);
    commit(5'd6, 4'd4, 32'hBB);
    step();
    clear_inputs();
    #1;
    check_eq("t4_final_qj", 32'(bus.dec_Qj_out), 32'd0);
    check_eq("t4_final_vj", bus.dec_Vj_out, 32'hBB);

    // 5: rollback clears tags, drops issue, keeps values and same-cycle commit
    issue(5'd7, 4'd2);
    step();
    issue(5'd8, 4'd3);
    step();
    clear_inputs();
    bus.rollback_in = 1'b1;
    issue(5'd9, 4'd4);
    commit(5'd10, 4'd7, 32'h55);
    step();
    clear_inputs();
    read(5'd7, 5'd8);
    check_eq("t5_q7", 32'(bus.dec_Qj_out), 32'd0);
    check_eq("t5_q8", 32'(bus.dec_Qk_out), 32'd0);
    check_eq("t5_v7", bus.dec_Vj_out, 32'd0);
    read(5'd9, 5'd10);
    check_eq("t5_q9", 32'(bus.dec_Qj_out), 32'd0);
    check_eq("t5_v10", bus.dec_Vk_out, 32'h55);
    read(5'd3, 5'd4);
    check_eq("t5_v3", bus.dec_Vj_out, 32'h1234);
    check_eq("t5_v4", bus.dec_Vk_out, 32'd9);

    // 6: x0 ignores issue and commit
    issue(5'd0, 4'd6);
    commit(5'd0, 4'd6, 32'hFFFF);
    read(5'd0, 5'd0);
    check_eq("x0_byp_qj", 32'(bus.dec_Qj_out), 32'd0);
    check_eq("x0_byp_vj", bus.dec_Vj_out, 32'd0);
    step();
    clear_inputs();
    #1;
    check_eq("x0_qj", 32'(bus.dec_Qj_out), 32'd0);
    check_eq("x0_vj", bus.dec_Vj_out, 32'd0);

    // mid-sequence reset with a pending tag
    issue(5'd11, 4'd5);
    step();
    clear_inputs();
    read(5'd11, 5'd0);
    check_eq("pre_rst_q11", 32'(bus.dec_Qj_out), 32'd5);
    rst = 1'b1;
    issue(5'd12, 4'd6);
    step();
    rst = 1'b0;
    clear_inputs();
    read(5'd11, 5'd3);
    check_eq("post_rst_q11", 32'(bus.dec_Qj_out), 32'd0);
    check_eq("post_rst_v3", bus.dec_Vk_out, 32'd0);
    read(5'd12, 5'd4);
    check_eq("post_rst_q12", 32'(bus.dec_Qj_out), 32'd0);
    check_eq("post_rst_v4", bus.dec_Vk_out, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
